// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first.
// Fixed latency of NDIGITS+1 cycles from start to the done pulse.
module bcd_to_bin #(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   busy,
  output logic                   done,
  output logic [BIN_W-1:0]       binary_out,
  output logic                   err
);

  localparam int CW = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [4*NDIGITS-1:0]  shreg_q, shreg_d;
  logic [BIN_W-1:0]      acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  eflag_q, eflag_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic                  err_q, err_d;

  logic [3:0]            dig;
  logic                  dig_bad;
  logic                  last;
  logic [BIN_W-1:0]      acc_nxt;

  assign dig     = shreg_q[4*NDIGITS-1 -: 4];
  assign dig_bad = (dig > 4'd9);
  assign last    = (cnt_q == CW'(NDIGITS - 1));
  // acc*10 as shift-add; modulo-2^BIN_W arithmetic equals the wide form truncated.
  assign acc_nxt = (acc_q << 3) + (acc_q << 1) + {{(BIN_W-4){1'b0}}, dig};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    eflag_d = eflag_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          eflag_d = 1'b0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        acc_d   = acc_nxt;
        shreg_d = shreg_q << 4;
        cnt_d   = cnt_q + 1'b1;
        eflag_d = eflag_q | dig_bad;
        if (last) begin
          // Results only move on the final digit, so they hold across start.
          state_d = ST_DONE;
          bin_d   = (eflag_q | dig_bad) ? '0 : acc_nxt;
          err_d   = eflag_q | dig_bad;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      eflag_q <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      eflag_q <= eflag_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q == ST_CONVERT);
  assign done       = (state_q == ST_DONE);
  assign binary_out = bin_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed table, random vectors vs. arithmetic model,
// and hand sequences for ignored start, mid-conversion reset and back-to-back.
module tb_bcd_to_bin;
  localparam int ND = 3;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4*ND-1:0] bcd_in = '0;
  logic          busy, done, err;
  logic [BW-1:0] binary_out;

  int errors = 0;
  int checks = 0;
  int prev_bin = 0;
  int prev_err = 0;

  bcd_to_bin #(.NDIGITS(ND), .BIN_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .binary_out(binary_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*ND-1:0] bcd;
    int              exp_bin;
    int              exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Decimal meaning of the packed digits; any digit above 9 makes it an error.
  function automatic void ref_conv(input logic [4*ND-1:0] b, output int v, output int e);
    int val;
    int d;
    logic [4*ND-1:0] t;
    val = 0; e = 0; t = b;
    for (int i = ND - 1; i >= 0; i--) begin
      d = int'(t[4*i +: 4]);
      if (d > 9) e = 1;
      val = val * 10 + d;
    end
    v = e ? 0 : val;
  endfunction

  // Called at a negedge with the DUT idle. noisy keeps start high with other
  // data during the conversion, which must be ignored.
  task automatic convert(input logic [4*ND-1:0] b, input int exp_bin, input int exp_err,
                         input bit noisy, input string nm);
    start = 1'b1; bcd_in = b;
    @(posedge clk); #1;
    start = noisy; bcd_in = noisy ? 12'h555 : 12'hFFF;
    for (int i = 1; i <= ND; i++) begin
      @(negedge clk);
      chk({nm, " busy"}, int'(busy), 1);
      chk({nm, " done_early"}, int'(done), 0);
      chk({nm, " held_bin"}, int'(binary_out), prev_bin);
    end
    @(negedge clk);
    start = 1'b0;
    chk({nm, " done"}, int'(done), 1);
    chk({nm, " busy_in_done"}, int'(busy), 0);
    chk({nm, " bin"}, int'(binary_out), exp_bin);
    chk({nm, " err"}, int'(err), exp_err);
    prev_bin = exp_bin; prev_err = exp_err;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({nm, " idle_done"}, int'(done), 0);
      chk({nm, " idle_busy"}, int'(busy), 0);
      chk({nm, " idle_bin"}, int'(binary_out), prev_bin);
    end
  endtask

  initial begin
    int v, e;
    logic [4*ND-1:0] rb;

    tbl[0] = '{12'h123, 123, 0};
    tbl[1] = '{12'h999, 999, 0};
    tbl[2] = '{12'h000,   0, 0};
    tbl[3] = '{12'h1A3,   0, 1};
    tbl[4] = '{12'h042,  42, 0};
    tbl[5] = '{12'h321, 321, 0};

    #2;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset bin", int'(binary_out), 0);
    chk("reset err", int'(err), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      convert(tbl[i].bcd, tbl[i].exp_bin, tbl[i].exp_err, 1'b0, $sformatf("tbl%0d", i));

    // start with other data during a conversion is dropped
    convert(tbl[5].bcd, tbl[5].exp_bin, tbl[5].exp_err, 1'b1, "ignore_start");

    // reset in the second conversion cycle aborts with everything cleared
    start = 1'b1; bcd_in = 12'h777;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort bin", int'(binary_out), 0);
    chk("abort err", int'(err), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_abort done", int'(done), 0);
    end
    prev_bin = 0; prev_err = 0;
    convert(12'h250, 250, 0, 1'b0, "after_reset");

    for (int n = 0; n < 20; n++) begin
      for (int d = 0; d < ND; d++)
        rb[4*d +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      ref_conv(rb, v, e);
      convert(rb, v, e, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    // start held high: one result every ND+2 cycles
    start = 1'b1; bcd_in = 12'h010;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("b2b busy k%0d", k), int'(busy), ((k % 5) >= 1 && (k % 5) <= 3) ? 1 : 0);
      chk($sformatf("b2b done k%0d", k), int'(done), ((k % 5) == 4) ? 1 : 0);
      if (k % 5 == 4) chk($sformatf("b2b bin k%0d", k), int'(binary_out), 10);
    end
    start = 1'b0;
    repeat (ND + 3) @(negedge clk);
    chk("final busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
